// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, a 2-entry skid buffer,
// a synchronous flush that inserts a NOP bubble, and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned             WIDTH = 32,
  parameter logic [WIDTH-1:0]        NOP   = '0,
  parameter int unsigned             CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] main_q, main_nx;
  logic [WIDTH-1:0] skid_q, skid_nx;
  logic             accept, pop;

  // Handshake outputs derive only from the state flop, so in_ready never
  // sees out_ready combinationally.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state == ONE) || (state == FULL);
    out_data  = out_valid ? main_q : NOP;
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Next-state and entry update; flush overrides any accept/pop this cycle.
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nx = ONE;
          main_nx  = in_data;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_nx = in_data;
        end else if (accept) begin
          state_nx = FULL;
          skid_nx  = in_data;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nx = ONE;
          main_nx  = skid_q;
        end
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end

  // Saturating back-pressure counter; flush does not touch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg against hand-computed
// values and a 2-deep queue model.
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH = 32;
  localparam logic [31:0] NOPV  = 32'h0000_0013;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(
    .WIDTH (WIDTH),
    .NOP   (NOPV),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic r, input int st);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".out_data"}, out_data, d);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, r});
    chk({tag, ".stall"}, {28'd0, stall_cycles}, st);
  endtask

  logic [31:0] q[$];
  int          exp_stall;
  logic        e_rdy, e_val, acc, pp;
  logic [31:0] e_dat;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, NOPV, 1'b1, 0);
    rst = 1'b1;

    // 1: streaming with downstream always ready
    in_valid = 1'b1; in_data = 32'h11; step(); chk_out("s1_11", 1'b1, 32'h11, 1'b1, 0);
    in_data = 32'h22; step(); chk_out("s1_22", 1'b1, 32'h22, 1'b1, 0);
    in_data = 32'h33; step(); chk_out("s1_33", 1'b1, 32'h33, 1'b1, 0);
    in_valid = 1'b0; step(); chk_out("s1_drain", 1'b0, NOPV, 1'b1, 0);

    // 2: fill skid under back-pressure, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1; step(); chk_out("s2_one", 1'b1, 32'hA1, 1'b1, 0);
    in_data = 32'hA2; step(); chk_out("s2_full", 1'b1, 32'hA1, 1'b0, 1);
    in_valid = 1'b0; step(); chk_out("s2_hold1", 1'b1, 32'hA1, 1'b0, 2);
    step(); chk_out("s2_hold2", 1'b1, 32'hA1, 1'b0, 3);
    out_ready = 1'b1; step(); chk_out("s2_popA1", 1'b1, 32'hA2, 1'b1, 3);
    step(); chk_out("s2_popA2", 1'b0, NOPV, 1'b1, 3);

    // 3: flush while FULL with a beat offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1; step(); chk_out("s3_b1", 1'b1, 32'hB1, 1'b1, 3);
    in_data = 32'hB2; step(); chk_out("s3_b2", 1'b1, 32'hB1, 1'b0, 4);
    flush = 1'b1; in_data = 32'hB3; step(); chk_out("s3_flush", 1'b0, NOPV, 1'b1, 5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step(); chk_out("s3_after", 1'b0, NOPV, 1'b1, 5);
    // flush kills a beat accepted in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC1; step(); chk_out("s3_c1", 1'b1, 32'hC1, 1'b1, 5);
    flush = 1'b1; in_data = 32'hC2; step(); chk_out("s3_flush2", 1'b0, NOPV, 1'b1, 6);
    flush = 1'b0; in_valid = 1'b0; step(); chk_out("s3_noC2", 1'b0, NOPV, 1'b1, 6);

    // 5: asynchronous reset between edges while FULL
    in_valid = 1'b1; in_data = 32'hD1; step();
    in_data = 32'hD2; step(); chk_out("s5_full", 1'b1, 32'hD1, 1'b0, 7);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_out("s5_async", 1'b0, NOPV, 1'b1, 0);
    #2 rst = 1'b1;
    step(); chk_out("s5_release", 1'b0, NOPV, 1'b1, 0);

    // 4: stall counter saturation with CNT_W=4
    in_valid = 1'b1; in_data = 32'hE1; step(); chk_out("s4_load", 1'b1, 32'hE1, 1'b1, 0);
    in_valid = 1'b0;
    repeat (14) step();
    chk_out("s4_14", 1'b1, 32'hE1, 1'b1, 14);
    step(); chk_out("s4_15", 1'b1, 32'hE1, 1'b1, 15);
    repeat (5) step();
    chk_out("s4_sat", 1'b1, 32'hE1, 1'b1, 15);
    out_ready = 1'b1; step(); chk_out("s4_pop", 1'b0, NOPV, 1'b1, 15);

    // 6: random traffic against a 2-deep queue model
    rst = 1'b0; #1 rst = 1'b1;
    q.delete();
    exp_stall = 0;
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 5);
      in_data   = $urandom;
      #1;
      e_rdy = (q.size() < 2);
      e_val = (q.size() > 0);
      e_dat = e_val ? q[0] : NOPV;
      chk_out("rand", e_val, e_dat, e_rdy, exp_stall);
      acc = in_valid && e_rdy;
      pp  = e_val && out_ready;
      if (e_val && !out_ready && exp_stall < 15) exp_stall++;
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
